// File: rtl/board_mem_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// board_mem_scheduler_pkg
//
// Shared definitions for the board memory scheduler and its read-tag pipeline.
//   WORD_SIZE     : bits per board word (cells per word)
//   LOG_MAX_ADDR  : word-address width within one board bank
//   req_tag_e     : identifies which requester issued a BRAM read
// ----------------------------------------------------------------------------
package board_mem_scheduler_pkg;

    localparam int unsigned WORD_SIZE    = 16;
    localparam int unsigned LOG_MAX_ADDR = 12;

    // Tag carried alongside each issued read so the returning word is routed
    // to the requester that asked for it.
    typedef enum logic [1:0] {
        TagNone = 2'd0,
        TagRen  = 2'd1,
        TagUpd  = 2'd2
    } req_tag_e;

endpackage

// File: rtl/board_mem_scheduler_read_tag_pipe.sv
// ----------------------------------------------------------------------------
// board_mem_scheduler_read_tag_pipe
//
// MEM_LATENCY-deep shift register of requester tags. A tag pushed in the cycle
// a read address is presented reaches the last stage in the cycle the BRAM
// returns that word, where it is decoded into per-requester strobes.
//
// Ports:
//   clk_in          : system clock
//   rst_in          : asynchronous active-low reset, clears every stage
//   tag_in          : tag of the read issued this cycle (TagNone if none)
//   ren_strobe_out  : mem_rdata_in belongs to the renderer this cycle
//   upd_strobe_out  : mem_rdata_in belongs to the update engine this cycle
// ----------------------------------------------------------------------------
module board_mem_scheduler_read_tag_pipe
    import board_mem_scheduler_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  req_tag_e tag_in,
    output logic     ren_strobe_out,
    output logic     upd_strobe_out
);

    req_tag_e tag_q [MEM_LATENCY];

    // Clearing on reset drops any read in flight: it can never strobe.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                tag_q[i] <= TagNone;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign ren_strobe_out = (tag_q[MEM_LATENCY-1] == TagRen);
    assign upd_strobe_out = (tag_q[MEM_LATENCY-1] == TagUpd);

endmodule

// File: rtl/board_mem_scheduler.sv
// ----------------------------------------------------------------------------
// board_mem_scheduler
//
// Owns the single-port board BRAM and shares it between the renderer fetch
// path (read-only, never stalled) and the life update engine (read + write).
// The board is double-buffered: the address MSB selects the bank. Both
// requesters read the display bank; the update engine writes the other one.
// A small generation FSM launches an update at a frame boundary and swaps the
// banks at the first frame boundary after the engine reports done.
//
// Ports:
//   clk_in, rst_in            : clock, asynchronous active-low reset
//   frame_start_in            : one-cycle pulse at start of vertical blank
//   step_en_in                : 1 = keep advancing generations
//   ren_req_in, ren_addr_in   : renderer read request / word address
//   ren_valid_out, ren_data_out
//                             : renderer read return (valid is a pulse)
//   upd_rd_req_in, upd_wr_req_in, upd_addr_in, upd_wdata_in
//                             : update engine request, held until granted
//   upd_gnt_out               : update request accepted this cycle (comb.)
//   upd_rd_valid_out, upd_rd_data_out
//                             : update engine read return
//   upd_start_out             : pulse, begin computing a generation
//   upd_done_in               : pulse, generation fully written
//   mem_addr_out, mem_we_out, mem_wdata_out, mem_rdata_in
//                             : BRAM port, address is {bank, word}
//   disp_bank_out             : bank currently displayed
//   gen_count_out             : completed, swapped generations
// ----------------------------------------------------------------------------
module board_mem_scheduler
    import board_mem_scheduler_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = board_mem_scheduler_pkg::WORD_SIZE,
    parameter int unsigned LOG_MAX_ADDR = board_mem_scheduler_pkg::LOG_MAX_ADDR,
    parameter int unsigned MEM_LATENCY  = 2,
    parameter int unsigned GEN_W        = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    frame_start_in,
    input  logic                    step_en_in,
    input  logic                    ren_req_in,
    input  logic [LOG_MAX_ADDR-1:0] ren_addr_in,
    output logic                    ren_valid_out,
    output logic [WORD_SIZE-1:0]    ren_data_out,
    input  logic                    upd_rd_req_in,
    input  logic                    upd_wr_req_in,
    input  logic [LOG_MAX_ADDR-1:0] upd_addr_in,
    input  logic [WORD_SIZE-1:0]    upd_wdata_in,
    output logic                    upd_gnt_out,
    output logic                    upd_rd_valid_out,
    output logic [WORD_SIZE-1:0]    upd_rd_data_out,
    output logic                    upd_start_out,
    input  logic                    upd_done_in,
    output logic [LOG_MAX_ADDR:0]   mem_addr_out,
    output logic                    mem_we_out,
    output logic [WORD_SIZE-1:0]    mem_wdata_out,
    input  logic [WORD_SIZE-1:0]    mem_rdata_in,
    output logic                    disp_bank_out,
    output logic [GEN_W-1:0]        gen_count_out
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StWaitSwap
    } gen_state_e;

    gen_state_e              state_q;
    logic                    disp_bank_q;
    logic [GEN_W-1:0]        gen_q;
    logic                    upd_start_q;

    logic [LOG_MAX_ADDR:0]   addr_q;
    logic [WORD_SIZE-1:0]    wdata_q;
    req_tag_e                issue_tag;

    logic                    ren_strobe;
    logic                    upd_strobe;
    logic                    ren_valid_q;
    logic                    upd_valid_q;
    logic [WORD_SIZE-1:0]    ren_data_q;
    logic [WORD_SIZE-1:0]    upd_data_q;

    logic                    swap_now;

    // ------------------------------------------------------------------------
    // Arbitration: renderer first, then update write, then update read.
    // With no request the BRAM address and write data keep their last values.
    // ------------------------------------------------------------------------
    always_comb begin
        mem_addr_out  = addr_q;
        mem_we_out    = 1'b0;
        mem_wdata_out = wdata_q;
        upd_gnt_out   = 1'b0;
        issue_tag     = TagNone;
        if (ren_req_in) begin
            mem_addr_out = {disp_bank_q, ren_addr_in};
            issue_tag    = TagRen;
        end else if (upd_wr_req_in) begin
            // A simultaneous update read is dropped; the engine must not do that.
            mem_addr_out  = {~disp_bank_q, upd_addr_in};
            mem_we_out    = 1'b1;
            mem_wdata_out = upd_wdata_in;
            upd_gnt_out   = 1'b1;
        end else if (upd_rd_req_in) begin
            mem_addr_out = {disp_bank_q, upd_addr_in};
            upd_gnt_out  = 1'b1;
            issue_tag    = TagUpd;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            addr_q  <= mem_addr_out;
            wdata_q <= mem_wdata_out;
        end
    end

    // ------------------------------------------------------------------------
    // Read return path
    // ------------------------------------------------------------------------
    board_mem_scheduler_read_tag_pipe #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_tag_pipe (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .tag_in         (issue_tag),
        .ren_strobe_out (ren_strobe),
        .upd_strobe_out (upd_strobe)
    );

    // Returned words are registered; data holds between valid pulses.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ren_valid_q <= 1'b0;
            upd_valid_q <= 1'b0;
            ren_data_q  <= '0;
            upd_data_q  <= '0;
        end else begin
            ren_valid_q <= ren_strobe;
            upd_valid_q <= upd_strobe;
            if (ren_strobe) begin
                ren_data_q <= mem_rdata_in;
            end
            if (upd_strobe) begin
                upd_data_q <= mem_rdata_in;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Generation sequencing
    // ------------------------------------------------------------------------
    // A done arriving together with a frame boundary swaps immediately, as if
    // the FSM had already been waiting for that boundary.
    assign swap_now = frame_start_in &&
                      ((state_q == StWaitSwap) || ((state_q == StRun) && upd_done_in));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= StIdle;
            disp_bank_q <= 1'b0;
            gen_q       <= '0;
            upd_start_q <= 1'b0;
        end else begin
            upd_start_q <= 1'b0;
            if (swap_now) begin
                disp_bank_q <= ~disp_bank_q;
                gen_q       <= gen_q + GEN_W'(1);
                if (step_en_in) begin
                    upd_start_q <= 1'b1;
                    state_q     <= StRun;
                end else begin
                    state_q     <= StIdle;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        if (frame_start_in && step_en_in) begin
                            upd_start_q <= 1'b1;
                            state_q     <= StRun;
                        end
                    end
                    // Frame boundaries during a generation are ignored; a
                    // generation is never aborted.
                    StRun: begin
                        if (upd_done_in) begin
                            state_q <= StWaitSwap;
                        end
                    end
                    StWaitSwap: begin
                        state_q <= StWaitSwap;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign ren_valid_out    = ren_valid_q;
    assign ren_data_out     = ren_data_q;
    assign upd_rd_valid_out = upd_valid_q;
    assign upd_rd_data_out  = upd_data_q;
    assign upd_start_out    = upd_start_q;
    assign disp_bank_out    = disp_bank_q;
    assign gen_count_out    = gen_q;

endmodule

// File: tb/tb_board_mem_scheduler.sv
// ----------------------------------------------------------------------------
// tb_board_mem_scheduler
//
// Drives the scheduler against a behavioural BRAM, compares every cycle to a
// transaction-level reference (shadow board array, queue of pending read
// returns, generation bookkeeping bits), runs a table of arbitration vectors,
// hand-written generation/reset sequences, then randomized traffic.
// ----------------------------------------------------------------------------
module tb_board_mem_scheduler;

    localparam int unsigned WS  = 16;
    localparam int unsigned AW  = 12;
    localparam int unsigned LAT = 2;
    localparam int unsigned GW  = 16;

    logic          clk_in;
    logic          rst_in;
    logic          frame_start_in;
    logic          step_en_in;
    logic          ren_req_in;
    logic [AW-1:0] ren_addr_in;
    logic          ren_valid_out;
    logic [WS-1:0] ren_data_out;
    logic          upd_rd_req_in;
    logic          upd_wr_req_in;
    logic [AW-1:0] upd_addr_in;
    logic [WS-1:0] upd_wdata_in;
    logic          upd_gnt_out;
    logic          upd_rd_valid_out;
    logic [WS-1:0] upd_rd_data_out;
    logic          upd_start_out;
    logic          upd_done_in;
    logic [AW:0]   mem_addr_out;
    logic          mem_we_out;
    logic [WS-1:0] mem_wdata_out;
    logic [WS-1:0] mem_rdata_in;
    logic          disp_bank_out;
    logic [GW-1:0] gen_count_out;

    board_mem_scheduler #(
        .WORD_SIZE    (WS),
        .LOG_MAX_ADDR (AW),
        .MEM_LATENCY  (LAT),
        .GEN_W        (GW)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .frame_start_in   (frame_start_in),
        .step_en_in       (step_en_in),
        .ren_req_in       (ren_req_in),
        .ren_addr_in      (ren_addr_in),
        .ren_valid_out    (ren_valid_out),
        .ren_data_out     (ren_data_out),
        .upd_rd_req_in    (upd_rd_req_in),
        .upd_wr_req_in    (upd_wr_req_in),
        .upd_addr_in      (upd_addr_in),
        .upd_wdata_in     (upd_wdata_in),
        .upd_gnt_out      (upd_gnt_out),
        .upd_rd_valid_out (upd_rd_valid_out),
        .upd_rd_data_out  (upd_rd_data_out),
        .upd_start_out    (upd_start_out),
        .upd_done_in      (upd_done_in),
        .mem_addr_out     (mem_addr_out),
        .mem_we_out       (mem_we_out),
        .mem_wdata_out    (mem_wdata_out),
        .mem_rdata_in     (mem_rdata_in),
        .disp_bank_out    (disp_bank_out),
        .gen_count_out    (gen_count_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Behavioural BRAM: read data appears LAT cycles after the address.
    bit [WS-1:0] bram  [0:(1<<(AW+1))-1];
    bit [WS-1:0] rpipe [LAT];

    always @(posedge clk_in) begin
        if (mem_we_out) bram[mem_addr_out] <= mem_wdata_out;
        rpipe[0] <= bram[mem_addr_out];
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata_in = rpipe[LAT-1];

    always @(negedge clk_in) begin
        if (rst_in && upd_rd_req_in && upd_wr_req_in)
            $error("update engine drove read and write together");
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        bit          is_ren;
        bit [WS-1:0] data;
    } rd_t;

    int          checks;
    int          failures;
    int          cyc;
    bit [WS-1:0] shadow [0:(1<<(AW+1))-1];
    rd_t         pend[$];
    bit          m_bank;
    bit [GW-1:0] m_gen;
    bit          m_running;
    bit          m_finished;
    bit          m_start;
    bit [AW:0]   m_last_addr;
    bit [WS-1:0] m_ren_data;
    bit [WS-1:0] m_upd_data;

    // Values sampled at the most recent negedge.
    logic          s_gnt, s_we, s_ren_v, s_upd_v, s_start, s_bank;
    logic [AW:0]   s_addr;
    logic [WS-1:0] s_wdata, s_ren_d, s_upd_d;
    logic [GW-1:0] s_gen;
    int            start_cnt, ren_v_cnt, upd_v_cnt, we_cnt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_bank      = 1'b0;
        m_gen       = '0;
        m_running   = 1'b0;
        m_finished  = 1'b0;
        m_start     = 1'b0;
        m_last_addr = '0;
        m_ren_data  = '0;
        m_upd_data  = '0;
    endtask

    function automatic bit [AW:0] exp_addr();
        if (ren_req_in)    return {m_bank, ren_addr_in};
        if (upd_wr_req_in) return {~m_bank, upd_addr_in};
        if (upd_rd_req_in) return {m_bank, upd_addr_in};
        return m_last_addr;
    endfunction

    task automatic check_cycle();
        bit  e_gnt, e_we, e_rv, e_uv;
        rd_t r;
        s_gnt   = upd_gnt_out;      s_we    = mem_we_out;
        s_addr  = mem_addr_out;     s_wdata = mem_wdata_out;
        s_ren_v = ren_valid_out;    s_upd_v = upd_rd_valid_out;
        s_ren_d = ren_data_out;     s_upd_d = upd_rd_data_out;
        s_start = upd_start_out;    s_bank  = disp_bank_out;
        s_gen   = gen_count_out;
        start_cnt += int'(s_start);
        ren_v_cnt += int'(s_ren_v);
        upd_v_cnt += int'(s_upd_v);
        we_cnt    += int'(s_we);

        e_gnt = !ren_req_in && (upd_wr_req_in || upd_rd_req_in);
        e_we  = !ren_req_in && upd_wr_req_in;
        e_rv  = 1'b0;
        e_uv  = 1'b0;
        if (pend.size() != 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            if (r.is_ren) begin e_rv = 1'b1; m_ren_data = r.data; end
            else          begin e_uv = 1'b1; m_upd_data = r.data; end
        end
        chk("upd_gnt", 32'(s_gnt), 32'(e_gnt));
        chk("mem_we", 32'(s_we), 32'(e_we));
        chk("mem_addr", 32'(s_addr), 32'(exp_addr()));
        if (e_we) chk("mem_wdata", 32'(s_wdata), 32'(upd_wdata_in));
        chk("ren_valid", 32'(s_ren_v), 32'(e_rv));
        chk("upd_rd_valid", 32'(s_upd_v), 32'(e_uv));
        chk("ren_data", 32'(s_ren_d), 32'(m_ren_data));
        chk("upd_rd_data", 32'(s_upd_d), 32'(m_upd_data));
        chk("upd_start", 32'(s_start), 32'(m_start));
        chk("disp_bank", 32'(s_bank), 32'(m_bank));
        chk("gen_count", 32'(s_gen), 32'(m_gen));
    endtask

    task automatic model_advance();
        bit nstart;
        rd_t r;
        nstart = 1'b0;
        if (ren_req_in) begin
            r.due = cyc + LAT + 1; r.is_ren = 1'b1; r.data = shadow[{m_bank, ren_addr_in}];
            pend.push_back(r);
        end else if (upd_wr_req_in) begin
            shadow[{~m_bank, upd_addr_in}] = upd_wdata_in;
        end else if (upd_rd_req_in) begin
            r.due = cyc + LAT + 1; r.is_ren = 1'b0; r.data = shadow[{m_bank, upd_addr_in}];
            pend.push_back(r);
        end
        m_last_addr = exp_addr();

        // Generation rules: a running generation finishes on done; a finished
        // one is swapped at the next frame boundary (possibly the same cycle).
        if (m_running && upd_done_in) begin
            m_running  = 1'b0;
            m_finished = 1'b1;
        end else if (!m_running && !m_finished && frame_start_in && step_en_in) begin
            m_running = 1'b1;
            nstart    = 1'b1;
        end
        if (m_finished && frame_start_in) begin
            m_bank     = ~m_bank;
            m_gen      = m_gen + 1'b1;
            m_finished = 1'b0;
            if (step_en_in) begin
                m_running = 1'b1;
                nstart    = 1'b1;
            end
        end
        m_start = nstart;
        cyc++;
    endtask

    task automatic step();
        @(negedge clk_in);
        check_cycle();
        model_advance();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_inputs();
        frame_start_in = 1'b0; step_en_in    = 1'b0;
        ren_req_in     = 1'b0; ren_addr_in   = '0;
        upd_rd_req_in  = 1'b0; upd_wr_req_in = 1'b0;
        upd_addr_in    = '0;   upd_wdata_in  = '0;
        upd_done_in    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_in = 1'b0;
        #1;
        chk("rst_ren_valid", 32'(ren_valid_out), 0);
        chk("rst_ren_data", 32'(ren_data_out), 0);
        chk("rst_upd_gnt", 32'(upd_gnt_out), 0);
        chk("rst_upd_rd_valid", 32'(upd_rd_valid_out), 0);
        chk("rst_upd_rd_data", 32'(upd_rd_data_out), 0);
        chk("rst_upd_start", 32'(upd_start_out), 0);
        chk("rst_mem_addr", 32'(mem_addr_out), 0);
        chk("rst_mem_we", 32'(mem_we_out), 0);
        chk("rst_mem_wdata", 32'(mem_wdata_out), 0);
        chk("rst_disp_bank", 32'(disp_bank_out), 0);
        chk("rst_gen_count", 32'(gen_count_out), 0);
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
    endtask

    // ---------------- arbitration vector table ----------------
    typedef struct {
        bit          ren;
        bit [AW-1:0] raddr;
        bit          rd;
        bit          wr;
        bit [AW-1:0] uaddr;
        bit [WS-1:0] wd;
        bit          egnt;
        bit          ewe;
        bit [AW:0]   eaddr;
        bit [WS-1:0] ewd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        clear_inputs();
        rst_in = 1'b1;
        #3;
        do_reset();

        // Idle after reset: no writes for 100 cycles.
        we_cnt = 0;
        repeat (100) step();
        chk("idle_we_count", 32'(we_cnt), 0);

        // Bank 0 is displayed here, so writes go to 0x1xxx.
        vecs[0] = '{1'b1, 12'h123, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 13'h0123, 16'h0};
        vecs[1] = '{1'b0, 12'h000, 1'b0, 1'b1, 12'h045, 16'h1111, 1'b1, 1'b1, 13'h1045, 16'h1111};
        vecs[2] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h067, 16'h0000, 1'b1, 1'b0, 13'h0067, 16'h0};
        vecs[3] = '{1'b1, 12'h0AA, 1'b0, 1'b1, 12'h0BB, 16'h2222, 1'b0, 1'b0, 13'h00AA, 16'h0};
        vecs[4] = '{1'b1, 12'h0CC, 1'b1, 1'b0, 12'h0DD, 16'h0000, 1'b0, 1'b0, 13'h00CC, 16'h0};
        vecs[5] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h0EE, 16'h0000, 1'b0, 1'b0, 13'h00CC, 16'h0};
        vecs[6] = '{1'b0, 12'h000, 1'b0, 1'b1, 12'h005, 16'hBEEF, 1'b1, 1'b1, 13'h1005, 16'hBEEF};
        vecs[7] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 13'h1005, 16'h0};
        for (int i = 0; i < 8; i++) begin
            ren_req_in    = vecs[i].ren;  ren_addr_in   = vecs[i].raddr;
            upd_rd_req_in = vecs[i].rd;   upd_wr_req_in = vecs[i].wr;
            upd_addr_in   = vecs[i].uaddr; upd_wdata_in = vecs[i].wd;
            step();
            chk($sformatf("vec%0d_gnt", i), 32'(s_gnt), 32'(vecs[i].egnt));
            chk($sformatf("vec%0d_we", i), 32'(s_we), 32'(vecs[i].ewe));
            chk($sformatf("vec%0d_addr", i), 32'(s_addr), 32'(vecs[i].eaddr));
            if (vecs[i].ewe) chk($sformatf("vec%0d_wdata", i), 32'(s_wdata), 32'(vecs[i].ewd));
        end
        clear_inputs();
        repeat (5) step();

        // Renderer vs update read conflict.
        ren_v_cnt = 0;
        upd_v_cnt = 0;
        ren_req_in = 1'b1; ren_addr_in = 12'h010;
        upd_rd_req_in = 1'b1; upd_addr_in = 12'h020;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("prio_gnt_blocked", 32'(s_gnt), 0);
            chk("prio_ren_addr", 32'(s_addr), 32'h0010);
        end
        ren_req_in = 1'b0;
        step();
        chk("prio_gnt_granted", 32'(s_gnt), 1);
        chk("prio_upd_addr", 32'(s_addr), 32'h0020);
        upd_rd_req_in = 1'b0;
        repeat (6) step();
        chk("prio_ren_valid_count", 32'(ren_v_cnt), 3);
        chk("prio_upd_valid_count", 32'(upd_v_cnt), 1);

        // Generation spanning several frames.
        start_cnt  = 0;
        step_en_in = 1'b1;
        frame_start_in = 1'b1; step(); frame_start_in = 1'b0;
        step();
        chk("gen_first_start", 32'(start_cnt), 1);
        repeat (498) step();
        upd_done_in = 1'b1; step(); upd_done_in = 1'b0;
        repeat (200) step();
        chk("gen_bank_before_swap", 32'(s_bank), 0);
        chk("gen_count_before_swap", 32'(s_gen), 0);
        frame_start_in = 1'b1; step(); frame_start_in = 1'b0;
        step();
        chk("gen_bank_after_swap", 32'(s_bank), 1);
        chk("gen_count_after_swap", 32'(s_gen), 1);
        chk("gen_second_start", 32'(start_cnt), 2);

        // Renderer now reads the bank the earlier write went to.
        ren_req_in = 1'b1; ren_addr_in = 12'h005;
        step();
        chk("steer_ren_addr", 32'(s_addr), 32'h1005);
        ren_req_in = 1'b0;
        repeat (LAT + 1) step();
        chk("steer_ren_data", 32'(s_ren_d), 32'hBEEF);

        // Done and frame boundary in the same cycle while running.
        upd_done_in = 1'b1; frame_start_in = 1'b1; step();
        upd_done_in = 1'b0; frame_start_in = 1'b0;
        step();
        chk("same_cycle_bank", 32'(s_bank), 0);
        chk("same_cycle_gen", 32'(s_gen), 2);
        chk("same_cycle_start", 32'(s_start), 1);

        // Pause mid-generation: finish, swap, then stay idle.
        step_en_in = 1'b0;
        repeat (5) step();
        upd_done_in = 1'b1; step(); upd_done_in = 1'b0;
        repeat (10) step();
        chk("pause_wait_bank", 32'(s_bank), 0);
        start_cnt = 0;
        frame_start_in = 1'b1; step(); frame_start_in = 1'b0;
        step();
        chk("pause_swap_bank", 32'(s_bank), 1);
        chk("pause_swap_gen", 32'(s_gen), 3);
        upd_done_in = 1'b1; step(); upd_done_in = 1'b0;
        repeat (20) step();
        frame_start_in = 1'b1; step(); frame_start_in = 1'b0;
        repeat (5) step();
        chk("pause_no_start", 32'(start_cnt), 0);
        chk("pause_idle_gen", 32'(s_gen), 3);

        // Reset one cycle after a read issue: that read never returns.
        ren_req_in = 1'b1; ren_addr_in = 12'h003;
        step();
        ren_v_cnt = 0;
        do_reset();
        repeat (8) step();
        chk("rst_mid_read_no_valid", 32'(ren_v_cnt), 0);

        // Randomized traffic on a small address window so reads hit writes.
        for (int i = 0; i < 3000; i++) begin
            int op;
            ren_req_in   = ($urandom_range(0, 1) == 1);
            ren_addr_in  = AW'($urandom_range(0, 15));
            op           = $urandom_range(0, 2);
            upd_rd_req_in = (op == 1);
            upd_wr_req_in = (op == 2);
            upd_addr_in  = AW'($urandom_range(0, 15));
            upd_wdata_in = WS'($urandom);
            frame_start_in = ($urandom_range(0, 39) == 0);
            upd_done_in    = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 99) == 0) step_en_in = ~step_en_in;
            step();
        end
        clear_inputs();
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
